alu_stage: RTL and testbench

ALU_STAGE -- requirements
Module: alu_stage

---
 rtl/alu_stage.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_alu_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// -----------------------------------------------------------------------------
// alu_stage
//   Multi-cycle 6502-style ALU stage. It accepts one operation, computes the
//   result and the new processor status P, and produces one write cycle
//   carrying register-file and P write strobes.
//
//   FSM: IDLE -> EXEC -> (BCD_ADJ) -> WRITE -> IDLE.
//   - Binary ops take IDLE/EXEC/WRITE, so one op per 3 cycles.
//   - Decimal ADC/SBC insert BCD_ADJ, which applies the nibble corrections.
//   - Illegal op codes return EXEC -> IDLE and pulse op_error.
//
// Ports
//   clk_2              : sole clock, rising edge
//   rst                : asynchronous, active-low reset
//   op_valid/op_ready  : request handshake (op_ready high only in IDLE)
//   op_code[3:0]       : 0 ADC 1 SBC 2 AND 3 ORA 4 EOR 5 ASL 6 LSR 7 ROL
//                        8 ROR 9 INC A DEC B CMP C BIT D TRANSFER, E-F illegal
//   a_in, b_in[7:0]    : operands (shifts, INC, DEC, TRANSFER use a_in)
//   dest_sel[1:0]      : 0 A, 1 X, 2 Y, 3 SP
//   status_in[7:0]     : current P (N7 V6 D3 Z1 C0)
//   data_out[7:0]      : registered result, held between writes
//   data_status[7:0]   : registered new P, held between writes
//   *_con              : one-hot write strobes, high only in WRITE
//   op_error           : one-cycle pulse during EXEC for an illegal op code
// -----------------------------------------------------------------------------
module alu_stage #(
  parameter logic BCD_EN = 1'b1
) (
  input  logic       clk_2,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [3:0] op_code,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [1:0] dest_sel,
  input  logic [7:0] status_in,
  output logic       op_ready,
  output logic [7:0] data_out,
  output logic [7:0] data_status,
  output logic       accumulator_con,
  output logic       x_con,
  output logic       y_con,
  output logic       stack_pointer_con,
  output logic       status_con,
  output logic       op_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    BCD_ADJ = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADC = 4'h0;
  localparam logic [3:0] OP_SBC = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_ORA = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4;
  localparam logic [3:0] OP_ASL = 4'h5;
  localparam logic [3:0] OP_LSR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_ROR = 4'h8;
  localparam logic [3:0] OP_INC = 4'h9;
  localparam logic [3:0] OP_DEC = 4'hA;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_BIT = 4'hC;
  localparam logic [3:0] OP_TRF = 4'hD;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_D = 3;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  // Control and latched operands
  state_t     state_q, state_d;
  logic       run_q,   run_d;
  logic [3:0] op_q,    op_d;
  logic [7:0] a_q,     a_d;
  logic [7:0] b_q,     b_d;
  logic [1:0] dest_q,  dest_d;
  logic [7:0] p_q,     p_d;

  // Binary ADC/SBC results carried from EXEC into BCD_ADJ
  logic [7:0] bin_q,   bin_d;
  logic       bin_c_q, bin_c_d;
  logic       half_q,  half_d;
  logic       v_q,     v_d;

  // Registered outputs
  logic [7:0] data_out_q,    data_out_d;
  logic [7:0] data_status_q, data_status_d;

  // Decoded properties of the latched op
  logic is_illegal, is_arith, writes_data, writes_status;

  assign is_illegal    = (op_q == 4'hE) || (op_q == 4'hF);
  assign is_arith      = (op_q == OP_ADC) || (op_q == OP_SBC);
  assign writes_data   = !is_illegal && (op_q != OP_CMP) && (op_q != OP_BIT);
  // A transfer into SP is a plain register move (TXS) and leaves P alone.
  assign writes_status = !is_illegal && !((op_q == OP_TRF) && (dest_q == 2'd3));

  // ---------------------------------------------------------------------------
  // Binary ALU on the latched operands
  // ---------------------------------------------------------------------------
  logic [7:0] b_eff;
  logic [8:0] sum9;
  logic       half;
  logic       v_bin;
  logic [7:0] res;
  logic [7:0] new_p;

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    b_eff = (op_q == OP_SBC) ? ~b_q : b_q;
    sum9  = {1'b0, a_q} + {1'b0, b_eff} + {8'b0, p_q[P_C]};
    // Carry out of the low nibble; for SBC its absence is a nibble borrow.
    half  = ({1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, p_q[P_C]}) > 5'd15;
    // Overflow: operands agree in sign and the result does not.
    v_bin = (a_q[7] == b_eff[7]) && (a_q[7] != sum9[7]);
    res   = 8'h00;
    new_p = p_q;

    unique case (op_q)
      OP_ADC, OP_SBC: begin
        res        = sum9[7:0];
        new_p[P_V] = v_bin;
        new_p[P_C] = sum9[8];
      end
      OP_AND: res = a_q & b_q;
      OP_ORA: res = a_q | b_q;
      OP_EOR: res = a_q ^ b_q;
      OP_ASL: begin
        res        = {a_q[6:0], 1'b0};
        new_p[P_C] = a_q[7];
      end
      OP_LSR: begin
        res        = {1'b0, a_q[7:1]};
        new_p[P_C] = a_q[0];
      end
      OP_ROL: begin
        res        = {a_q[6:0], p_q[P_C]};
        new_p[P_C] = a_q[7];
      end
      OP_ROR: begin
        res        = {p_q[P_C], a_q[7:1]};
        new_p[P_C] = a_q[0];
      end
      OP_INC: res = a_q + 8'h01;
      OP_DEC: res = a_q - 8'h01;
      OP_CMP: begin
        res        = a_q - b_q;
        new_p[P_C] = (a_q >= b_q);
      end
      OP_TRF: res = a_q;
      default: res = 8'h00;
    endcase

    // N and Z follow the result for every op except BIT, which has its own.
    if (op_q == OP_BIT) begin
      new_p[P_N] = b_q[7];
      new_p[P_V] = b_q[6];
      new_p[P_Z] = ((a_q & b_q) == 8'h00);
    end else begin
      new_p[P_N] = res[7];
      new_p[P_Z] = (res == 8'h00);
    end
  end

  // ---------------------------------------------------------------------------
  // Decimal correction of the stored binary ADC/SBC result
  // ---------------------------------------------------------------------------
  logic       low_adj, hi_adj, bcd_c;
  logic [8:0] s1;
  logic [7:0] bcd_res;
  logic [7:0] bcd_p;

  always_comb begin
    low_adj = 1'b0;
    hi_adj  = 1'b0;
    s1      = 9'h000;
    bcd_res = 8'h00;
    bcd_c   = 1'b0;
    if (op_q == OP_SBC) begin
      low_adj = !half_q;
      hi_adj  = !bin_c_q;
      bcd_res = bin_q - (low_adj ? 8'h06 : 8'h00) - (hi_adj ? 8'h60 : 8'h00);
      bcd_c   = bin_c_q;
    end else begin
      low_adj = half_q || (bin_q[3:0] > 4'd9);
      s1      = {bin_c_q, bin_q} + (low_adj ? 9'h006 : 9'h000);
      // High digit is judged after the low correction (99+01 -> 9A -> A0 -> 00).
      hi_adj  = s1[8] || (s1[7:4] > 4'd9);
      bcd_res = s1[7:0] + (hi_adj ? 8'h60 : 8'h00);
      bcd_c   = hi_adj;
    end
    bcd_p      = p_q;
    bcd_p[P_N] = bcd_res[7];
    bcd_p[P_V] = v_q;
    bcd_p[P_Z] = (bcd_res == 8'h00);
    bcd_p[P_C] = bcd_c;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    dest_d        = dest_q;
    p_d           = p_q;
    bin_d         = bin_q;
    bin_c_d       = bin_c_q;
    half_d        = half_q;
    v_d           = v_q;
    data_out_d    = data_out_q;
    data_status_d = data_status_q;

    unique case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          op_d    = op_code;
          a_d     = a_in;
          b_d     = b_in;
          dest_d  = dest_sel;
          p_d     = status_in;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_illegal) begin
          state_d = IDLE;
        end else if (BCD_EN && is_arith && p_q[P_D]) begin
          bin_d   = sum9[7:0];
          bin_c_d = sum9[8];
          half_d  = half;
          v_d     = v_bin;
          state_d = BCD_ADJ;
        end else begin
          if (writes_data)   data_out_d    = res;
          if (writes_status) data_status_d = new_p;
          state_d = WRITE;
        end
      end
      BCD_ADJ: begin
        data_out_d    = bcd_res;
        data_status_d = bcd_p;
        state_d       = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: every flop, including the operand latches, is reset; they are a few
  // registers rather than a memory array, and a known value keeps
  // post-reset behaviour deterministic.
  always_ff @(posedge clk_2 or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      op_q          <= 4'h0;
      a_q           <= 8'h00;
      b_q           <= 8'h00;
      dest_q        <= 2'd0;
      p_q           <= 8'h00;
      bin_q         <= 8'h00;
      bin_c_q       <= 1'b0;
      half_q        <= 1'b0;
      v_q           <= 1'b0;
      data_out_q    <= 8'h00;
      data_status_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      dest_q        <= dest_d;
      p_q           <= p_d;
      bin_q         <= bin_d;
      bin_c_q       <= bin_c_d;
      half_q        <= half_d;
      v_q           <= v_d;
      data_out_q    <= data_out_d;
      data_status_q <= data_status_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  logic in_write;
  assign in_write = (state_q == WRITE);

  // run_q holds op_ready low through reset and rises on the first edge after
  // release.
  assign op_ready          = (state_q == IDLE) && run_q;
  assign op_error          = (state_q == EXEC) && is_illegal;
  assign data_out          = data_out_q;
  assign data_status       = data_status_q;
  assign accumulator_con   = in_write && writes_data && (dest_q == 2'd0);
  assign x_con             = in_write && writes_data && (dest_q == 2'd1);
  assign y_con             = in_write && writes_data && (dest_q == 2'd2);
  assign stack_pointer_con = in_write && writes_data && (dest_q == 2'd3);
  assign status_con        = in_write && writes_status;

endmodule

// File: tb/tb_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_stage
//   Directed bench for alu_stage. The driver issues operations and pushes the
//   hand-computed write-cycle response onto a scoreboard queue; a monitor on
//   the falling edge pops and compares whenever any write strobe is high.
//   Strobe vector order: {accumulator, x, y, stack_pointer, status}.
//   Latency counts rising edges from the accept edge through the edge that
//   enters WRITE, inclusive.
// -----------------------------------------------------------------------------
module tb_alu_stage;

  logic       clk_2 = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [3:0] op_code;
  logic [7:0] a_in, b_in;
  logic [1:0] dest_sel;
  logic [7:0] status_in;
  logic       op_ready;
  logic [7:0] data_out, data_status;
  logic       accumulator_con, x_con, y_con, stack_pointer_con, status_con;
  logic       op_error;

  alu_stage #(.BCD_EN(1'b1)) dut (
    .clk_2             (clk_2),
    .rst               (rst),
    .op_valid          (op_valid),
    .op_code           (op_code),
    .a_in              (a_in),
    .b_in              (b_in),
    .dest_sel          (dest_sel),
    .status_in         (status_in),
    .op_ready          (op_ready),
    .data_out          (data_out),
    .data_status       (data_status),
    .accumulator_con   (accumulator_con),
    .x_con             (x_con),
    .y_con             (y_con),
    .stack_pointer_con (stack_pointer_con),
    .status_con        (status_con),
    .op_error          (op_error)
  );

  always #5 clk_2 = ~clk_2;

  int cyc = 0;
  always @(posedge clk_2) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] out;
    logic [7:0] stat;
    logic [4:0] strb;
    int         acc;
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   last_acc = 0;
  int   prev_acc = 0;

  // Issue one operation; when push is set, queue its expected write cycle.
  task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] d, input logic [7:0] p,
                       input logic [7:0] eo, input logic [7:0] es,
                       input logic [4:0] strb, input int lat, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk_2);
    while (!op_ready && n < 50) begin
      @(negedge clk_2);
      n++;
    end
    if (!op_ready) begin
      check({tag, "_ready_timeout"}, 32'(op_ready), 32'd1);
      return;
    end
    op_code   = op;
    a_in      = a;
    b_in      = b;
    dest_sel  = d;
    status_in = p;
    op_valid  = 1'b1;
    @(posedge clk_2);
    #1;
    prev_acc = last_acc;
    last_acc = cyc;
    op_valid = 1'b0;
    if (push) begin
      e.out  = eo;
      e.stat = es;
      e.strb = strb;
      e.acc  = last_acc;
      e.lat  = lat;
      e.tag  = tag;
      sb.push_back(e);
    end
  endtask

  // Monitor: any strobe means a write cycle, which must match the queue head.
  always @(negedge clk_2) begin
    logic [4:0] strb;
    exp_t       e;
    strb = {accumulator_con, x_con, y_con, stack_pointer_con, status_con};
    if (strb != 5'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'(strb), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_data_out"},    32'(data_out),    32'(e.out));
        check({e.tag, "_data_status"}, 32'(data_status), 32'(e.stat));
        check({e.tag, "_strobes"},     32'(strb),        32'(e.strb));
        check({e.tag, "_latency"},     32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic check_idle_outputs(input string tag, input logic [7:0] eo, input logic [7:0] es);
    check({tag, "_data_out"},    32'(data_out),    32'(eo));
    check({tag, "_data_status"}, 32'(data_status), 32'(es));
    check({tag, "_strobes"},
          32'({accumulator_con, x_con, y_con, stack_pointer_con, status_con}), 32'd0);
    check({tag, "_op_error"},    32'(op_error),    32'd0);
    check({tag, "_op_ready"},    32'(op_ready),    32'd0);
  endtask

  task automatic illegal(input string tag, input logic [3:0] op);
    issue(tag, op, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 5'b0, 0, 1'b0);
    @(negedge clk_2);
    check({tag, "_op_error_exec"},  32'(op_error), 32'd1);
    check({tag, "_op_ready_exec"},  32'(op_ready), 32'd0);
    @(negedge clk_2);
    check({tag, "_op_error_after"}, 32'(op_error), 32'd0);
    check({tag, "_op_ready_after"}, 32'(op_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    op_valid  = 1'b0;
    op_code   = 4'h0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    dest_sel  = 2'd0;
    status_in = 8'h00;
    #1;
    check_idle_outputs("reset", 8'h00, 8'h00);
    repeat (3) @(negedge clk_2);
    rst = 1'b1;

    //     tag        op    a      b      dst   P      out    stat   strobes  lat
    issue("v1_adc",   4'h0, 8'h50, 8'h50, 2'd0, 8'h00, 8'hA0, 8'hC0, 5'b10001, 2, 1);
    issue("sbc_bin",  4'h1, 8'h50, 8'h30, 2'd1, 8'h01, 8'h20, 8'h01, 5'b01001, 2, 1);
    check("throughput", 32'(last_acc - prev_acc), 32'd3);
    issue("and",      4'h2, 8'hF0, 8'h0F, 2'd2, 8'hC3, 8'h00, 8'h43, 5'b00101, 2, 1);
    issue("asl",      4'h5, 8'h81, 8'h00, 2'd0, 8'h00, 8'h02, 8'h01, 5'b10001, 2, 1);
    issue("ror",      4'h8, 8'h01, 8'h00, 2'd0, 8'h01, 8'h80, 8'h81, 5'b10001, 2, 1);
    issue("lsr",      4'h6, 8'hFF, 8'h00, 2'd0, 8'h80, 8'h7F, 8'h01, 5'b10001, 2, 1);
    issue("inc_wrap", 4'h9, 8'hFF, 8'h00, 2'd0, 8'h00, 8'h00, 8'h02, 5'b10001, 2, 1);
    issue("dec_wrap", 4'hA, 8'h00, 8'h00, 2'd0, 8'h00, 8'hFF, 8'h80, 5'b10001, 2, 1);
    issue("v3_cmp",   4'hB, 8'h10, 8'h20, 2'd0, 8'h00, 8'hFF, 8'h80, 5'b00001, 2, 1);
    issue("bit",      4'hC, 8'h0F, 8'hC0, 2'd1, 8'h00, 8'hFF, 8'hC2, 5'b00001, 2, 1);
    issue("v4_trf",   4'hD, 8'h80, 8'h00, 2'd3, 8'h00, 8'h80, 8'hC2, 5'b00010, 2, 1);
    issue("v2_bcd_a", 4'h0, 8'h19, 8'h28, 2'd0, 8'h08, 8'h47, 8'h08, 5'b10001, 3, 1);
    issue("v2_bcd_b", 4'h0, 8'h99, 8'h01, 2'd0, 8'h08, 8'h00, 8'h0B, 5'b10001, 3, 1);
    issue("bcd_sbc",  4'h1, 8'h42, 8'h13, 2'd0, 8'h09, 8'h29, 8'h09, 5'b10001, 3, 1);
    issue("ora_zero", 4'h3, 8'h00, 8'h00, 2'd1, 8'h00, 8'h00, 8'h02, 5'b01001, 2, 1);
    issue("eor_dset", 4'h4, 8'hAA, 8'hFF, 2'd2, 8'h08, 8'h55, 8'h08, 5'b00101, 2, 1);
    issue("rol",      4'h7, 8'h80, 8'h00, 2'd0, 8'h00, 8'h00, 8'h03, 5'b10001, 2, 1);

    illegal("v5_opF", 4'hF);
    illegal("opE",    4'hE);

    // Abort an ADC while in EXEC; no write cycle may follow.
    issue("v6_abort", 4'h0, 8'h01, 8'h02, 2'd0, 8'h00, 8'h00, 8'h00, 5'b0, 0, 1'b0);
    rst = 1'b0;
    #1;
    check_idle_outputs("v6_reset", 8'h00, 8'h00);
    repeat (3) @(negedge clk_2);
    rst = 1'b1;
    @(negedge clk_2);
    check("v6_ready_after_release", 32'(op_ready), 32'd1);
    issue("v6_next",  4'h0, 8'h01, 8'h01, 2'd0, 8'h00, 8'h02, 8'h00, 5'b10001, 2, 1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_2);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk_2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
